feedback_rx: RTL and testbench

//  Receive end of the 5-word feedback packet (fsourceID, fbatteryStat, fValue, fclusterID, fdestinationID).
//  - Accepts the words in that order over a valid/ready word stream from the radio/link layer.
//  - Filters on destination, then writes the sender's battery and value into node memory.
//  - Pulses done when the packet has been consumed.

---
 rtl/feedback_rx_pkg.sv | 32 +++
 rtl/feedback_rx_addr_gen.sv | 12 +
 rtl/feedback_rx.sv | 138 +++++++++++++
 tb/tb_feedback_rx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feedback_rx_pkg.sv
// Shared definitions for the feedback packet path: FSM encodings, packet word
// indices and the node-memory table bases used by both receiver and transmitter.
package feedback_rx_pkg;

    localparam int unsigned WORD_WIDTH = 16;
    localparam int unsigned PKT_WORDS  = 5;
    localparam int unsigned IDX_WIDTH  = 3;

    localparam logic [IDX_WIDTH-1:0] W_SRC  = IDX_WIDTH'(0);
    localparam logic [IDX_WIDTH-1:0] W_BATT = IDX_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0] W_VAL  = IDX_WIDTH'(2);
    localparam logic [IDX_WIDTH-1:0] W_CLU  = IDX_WIDTH'(3);
    localparam logic [IDX_WIDTH-1:0] W_DST  = IDX_WIDTH'(4);

    localparam logic [WORD_WIDTH-1:0] BATT_BASE = 16'h0148;
    localparam logic [WORD_WIDTH-1:0] QVAL_BASE = 16'h01C8;
    localparam logic [WORD_WIDTH-1:0] BCAST_ID  = 16'hFFFF;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        S_SRC   = 4'd1,
        S_BATT  = 4'd2,
        S_VAL   = 4'd3,
        S_CLU   = 4'd4,
        S_DST   = 4'd5,
        CHECK   = 4'd6,
        WR_BATT = 4'd7,
        WR_VAL  = 4'd8,
        FIN     = 4'd9
    } fb_state_t;

endpackage

// File: rtl/feedback_rx_addr_gen.sv
// Table address generator: base + id*2, wrapping modulo 2^W.
module fb_addr_gen #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] base,
    input  logic [W-1:0] id,
    output logic [W-1:0] addr_c
);

    assign addr_c = base + (id << 1);

endmodule

// File: rtl/feedback_rx.sv
// Feedback packet receiver: captures the 5-word packet, filters on destination
// and writes battery/value tables. Define CLUSTER_FILTER_EN to also require a cluster match.
module feedback_rx
    import feedback_rx_pkg::*;
(
    input  logic                  clock,
    input  logic                  nreset,
    input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
    input  logic [WORD_WIDTH-1:0] MY_CLUSTER_ID,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [WORD_WIDTH-1:0] address,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  done,
    output logic                  drop
);

`ifdef CLUSTER_FILTER_EN
    localparam logic CLUSTER_FILTER = 1'b1;
`else
    localparam logic CLUSTER_FILTER = 1'b0;
`endif

    fb_state_t             state;
    logic [WORD_WIDTH-1:0] words [PKT_WORDS];
    logic                  drop_pend;

    logic [WORD_WIDTH-1:0] batt_addr_c;
    logic [WORD_WIDTH-1:0] qval_addr_c;
    logic                  accept_c;
    logic                  dst_hit_c;
    logic                  bcast_c;
    logic                  clu_hit_c;
    logic                  match_c;

    assign accept_c  = in_valid & in_ready;
    assign dst_hit_c = (words[W_DST] == MY_NODE_ID);
    assign bcast_c   = (words[W_DST] == BCAST_ID);
    assign clu_hit_c = (words[W_CLU] == MY_CLUSTER_ID);
    // Broadcast always crosses clusters; a unicast hit needs the cluster only when filtering.
    assign match_c   = bcast_c | (dst_hit_c & (~CLUSTER_FILTER | clu_hit_c));

    fb_addr_gen #(.W(WORD_WIDTH)) u_batt_addr (
        .base   (BATT_BASE),
        .id     (words[W_SRC]),
        .addr_c (batt_addr_c)
    );

    fb_addr_gen #(.W(WORD_WIDTH)) u_qval_addr (
        .base   (QVAL_BASE),
        .id     (words[W_SRC]),
        .addr_c (qval_addr_c)
    );

    // Outputs are registered from the current state, so they trail it by one cycle.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            words     <= '{default: '0};
            drop_pend <= 1'b0;
            in_ready  <= 1'b0;
            wr_en     <= 1'b0;
            address   <= '0;
            data_out  <= '0;
            done      <= 1'b0;
            drop      <= 1'b0;
        end else begin
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            done     <= 1'b0;
            drop     <= 1'b0;
            case (state)
                IDLE: state <= S_SRC;
                S_SRC: begin
                    in_ready <= 1'b1;
                    if (accept_c) begin
                        words[W_SRC] <= in_data;
                        state        <= S_BATT;
                    end
                end
                S_BATT: begin
                    in_ready <= 1'b1;
                    if (accept_c) begin
                        words[W_BATT] <= in_data;
                        state         <= S_VAL;
                    end
                end
                S_VAL: begin
                    in_ready <= 1'b1;
                    if (accept_c) begin
                        words[W_VAL] <= in_data;
                        state        <= S_CLU;
                    end
                end
                S_CLU: begin
                    in_ready <= 1'b1;
                    if (accept_c) begin
                        words[W_CLU] <= in_data;
                        state        <= S_DST;
                    end
                end
                // Drop ready on the final word so no stray word is taken in CHECK.
                S_DST: begin
                    in_ready <= ~accept_c;
                    if (accept_c) begin
                        words[W_DST] <= in_data;
                        state        <= CHECK;
                    end
                end
                CHECK: begin
                    drop_pend <= ~match_c;
                    state     <= match_c ? WR_BATT : FIN;
                end
                WR_BATT: begin
                    wr_en    <= 1'b1;
                    address  <= batt_addr_c;
                    data_out <= words[W_BATT];
                    state    <= WR_VAL;
                end
                WR_VAL: begin
                    wr_en    <= 1'b1;
                    address  <= qval_addr_c;
                    data_out <= words[W_VAL];
                    state    <= FIN;
                end
                FIN: begin
                    done  <= 1'b1;
                    drop  <= drop_pend;
                    state <= S_SRC;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_feedback_rx.sv
// Directed self-checking bench for feedback_rx.
module tb_feedback_rx;

    logic        clock = 1'b0;
    logic        nreset;
    logic [15:0] MY_NODE_ID;
    logic [15:0] MY_CLUSTER_ID;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        wr_en;
    logic [15:0] address;
    logic [15:0] data_out;
    logic        done;
    logic        drop;

    int n_checks = 0;
    int n_pass   = 0;

    int          cyc = 0;
    int          last_acc = 0;
    int          wr_n = 0;
    logic [31:0] wr_log [64];
    int          wr_cyc [64];
    int          done_n = 0;
    logic        done_drop [64];
    int          done_cyc [64];
    int          stray_drop = 0;

`ifdef CLUSTER_FILTER_EN
    localparam bit FILTER_BUILD = 1'b1;
`else
    localparam bit FILTER_BUILD = 1'b0;
`endif

    feedback_rx dut (
        .clock         (clock),
        .nreset        (nreset),
        .MY_NODE_ID    (MY_NODE_ID),
        .MY_CLUSTER_ID (MY_CLUSTER_ID),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .wr_en         (wr_en),
        .address       (address),
        .data_out      (data_out),
        .done          (done),
        .drop          (drop)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Event log sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (wr_en) begin
            wr_log[6'(wr_n)] = {address, data_out};
            wr_cyc[6'(wr_n)] = cyc;
            wr_n++;
        end
        if (done) begin
            done_drop[6'(done_n)] = drop;
            done_cyc[6'(done_n)]  = cyc;
            done_n++;
        end
        if (drop && !done) stray_drop++;
        if (in_valid && in_ready) last_acc = cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic send_word(input logic [15:0] d, input int gap);
        int n;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clock); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        n_checks++;
        if (n >= 50) $display("FAIL send_word_ready got %b want 1 within 50 cycles", in_ready);
        else n_pass++;
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_data  = 16'h0000;
    endtask

    task automatic send_packet(input logic [15:0] s, b, v, c, d, input int gap);
        send_word(s, gap);
        send_word(b, gap);
        send_word(v, gap);
        send_word(c, gap);
        send_word(d, gap);
    endtask

    task automatic wait_done(input int db, input int npkt);
        int n;
        n = 0;
        while (done_n - db < npkt && n < 60) begin
            @(posedge clock); #1;
            n++;
        end
        repeat (4) begin
            @(posedge clock); #1;
        end
        n_checks++;
        if (done_n - db != npkt) $display("FAIL wait_done_count got %0d want %0d", done_n - db, npkt);
        else n_pass++;
    endtask

    task automatic test_reset();
        nreset = 1'b0; in_valid = 1'b0; in_data = 16'h0000;
        MY_NODE_ID = 16'd3; MY_CLUSTER_ID = 16'd1;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({in_ready, wr_en, done, drop} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {in_ready, wr_en, done, drop});
        else n_pass++;
        n_checks++;
        if ({address, data_out} !== 32'h0) $display("FAIL reset_bus got %h want 00000000", {address, data_out});
        else n_pass++;
        nreset = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL ready_first_cycle got %b want 0", in_ready);
        else n_pass++;
        @(posedge clock); #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL ready_second_cycle got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_match(input int gap, input string tag);
        int wb, db;
        wb = wr_n; db = done_n;
        send_packet(16'd5, 16'h0040, 16'h0123, 16'd1, 16'd3, gap);
        wait_done(db, 1);
        n_checks++;
        if (wr_n - wb != 2) $display("FAIL %s_wr_count got %0d want 2", tag, wr_n - wb);
        else n_pass++;
        n_checks++;
        if (wr_log[6'(wb)] !== 32'h0152_0040) $display("FAIL %s_wr0 got %h want 01520040", tag, wr_log[6'(wb)]);
        else n_pass++;
        n_checks++;
        if (wr_log[6'(wb + 1)] !== 32'h01D2_0123) $display("FAIL %s_wr1 got %h want 01d20123", tag, wr_log[6'(wb + 1)]);
        else n_pass++;
        n_checks++;
        if (wr_cyc[6'(wb)] - last_acc != 2) $display("FAIL %s_wr_latency got %0d want 2", tag, wr_cyc[6'(wb)] - last_acc);
        else n_pass++;
        n_checks++;
        if (done_drop[6'(db)] !== 1'b0) $display("FAIL %s_drop got %b want 0", tag, done_drop[6'(db)]);
        else n_pass++;
        n_checks++;
        if (done_cyc[6'(db)] - last_acc != 4) $display("FAIL %s_done_latency got %0d want 4", tag, done_cyc[6'(db)] - last_acc);
        else n_pass++;
    endtask

    task automatic test_drop();
        int wb, db;
        wb = wr_n; db = done_n;
        send_packet(16'd5, 16'h0040, 16'h0123, 16'd1, 16'd7, 0);
        wait_done(db, 1);
        n_checks++;
        if (wr_n - wb != 0) $display("FAIL drop_wr_count got %0d want 0", wr_n - wb);
        else n_pass++;
        n_checks++;
        if (done_drop[6'(db)] !== 1'b1) $display("FAIL drop_flag got %b want 1", done_drop[6'(db)]);
        else n_pass++;
        n_checks++;
        if (done_cyc[6'(db)] - last_acc != 2) $display("FAIL drop_done_latency got %0d want 2", done_cyc[6'(db)] - last_acc);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int wb, db;
        wb = wr_n; db = done_n;
        send_packet(16'h7FFF, 16'h00AA, 16'h0BBB, 16'd9, 16'hFFFF, 0);
        wait_done(db, 1);
        n_checks++;
        if (wr_n - wb != 2) $display("FAIL wrap_wr_count got %0d want 2", wr_n - wb);
        else n_pass++;
        n_checks++;
        if (wr_log[6'(wb)] !== 32'h0146_00AA) $display("FAIL wrap_wr0 got %h want 014600aa", wr_log[6'(wb)]);
        else n_pass++;
        n_checks++;
        if (wr_log[6'(wb + 1)] !== 32'h01C6_0BBB) $display("FAIL wrap_wr1 got %h want 01c60bbb", wr_log[6'(wb + 1)]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int wb, db;
        wb = wr_n; db = done_n;
        // Self-feedback broadcast, then a unicast whose first word waits out the write phase.
        send_packet(16'd3, 16'h0AAA, 16'h0BBB, 16'd2, 16'hFFFF, 0);
        send_packet(16'd9, 16'h0001, 16'h0002, 16'd1, 16'd3, 0);
        wait_done(db, 2);
        n_checks++;
        if (wr_n - wb != 4) $display("FAIL b2b_wr_count got %0d want 4", wr_n - wb);
        else n_pass++;
        n_checks++;
        if ({wr_log[6'(wb)], wr_log[6'(wb + 1)]} !== 64'h014E_0AAA_01CE_0BBB)
            $display("FAIL b2b_pkt0 got %h %h want 014e0aaa 01ce0bbb", wr_log[6'(wb)], wr_log[6'(wb + 1)]);
        else n_pass++;
        n_checks++;
        if ({wr_log[6'(wb + 2)], wr_log[6'(wb + 3)]} !== 64'h015A_0001_01DA_0002)
            $display("FAIL b2b_pkt1 got %h %h want 015a0001 01da0002", wr_log[6'(wb + 2)], wr_log[6'(wb + 3)]);
        else n_pass++;
        n_checks++;
        if ({done_drop[6'(db)], done_drop[6'(db + 1)]} !== 2'b00)
            $display("FAIL b2b_drop got %b want 00", {done_drop[6'(db)], done_drop[6'(db + 1)]});
        else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        int wb, db;
        wb = wr_n; db = done_n;
        send_word(16'd5, 0);
        send_word(16'h0040, 0);
        send_word(16'h0123, 0);
        nreset = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, wr_en, done, drop, address, data_out} !== 36'h0)
            $display("FAIL midrst_outputs got %h want 000000000", {in_ready, wr_en, done, drop, address, data_out});
        else n_pass++;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({in_ready, wr_en, done} !== 3'b000) $display("FAIL midrst_held got %b want 000", {in_ready, wr_en, done});
        else n_pass++;
        nreset = 1'b1;
        send_packet(16'd6, 16'h0011, 16'h0022, 16'd1, 16'd3, 0);
        wait_done(db, 1);
        n_checks++;
        if (wr_n - wb != 2) $display("FAIL midrst_wr_count got %0d want 2", wr_n - wb);
        else n_pass++;
        n_checks++;
        if ({wr_log[6'(wb)], wr_log[6'(wb + 1)]} !== 64'h0154_0011_01D4_0022)
            $display("FAIL midrst_writes got %h %h want 01540011 01d40022", wr_log[6'(wb)], wr_log[6'(wb + 1)]);
        else n_pass++;
    endtask

    task automatic test_cluster();
        int wb, db;
        logic exp_drop;
        int   exp_wr;
        exp_drop = FILTER_BUILD;
        exp_wr   = FILTER_BUILD ? 0 : 2;
        wb = wr_n; db = done_n;
        send_packet(16'd4, 16'h0004, 16'h0044, 16'd2, 16'd3, 0);
        wait_done(db, 1);
        n_checks++;
        if (wr_n - wb != exp_wr) $display("FAIL clu_unicast_wr_count got %0d want %0d", wr_n - wb, exp_wr);
        else n_pass++;
        n_checks++;
        if (done_drop[6'(db)] !== exp_drop) $display("FAIL clu_unicast_drop got %b want %b", done_drop[6'(db)], exp_drop);
        else n_pass++;
        wb = wr_n; db = done_n;
        send_packet(16'd4, 16'h0004, 16'h0044, 16'd2, 16'hFFFF, 0);
        wait_done(db, 1);
        n_checks++;
        if ({wr_log[6'(wb)], wr_log[6'(wb + 1)]} !== 64'h0150_0004_01D0_0044)
            $display("FAIL clu_bcast_writes got %h %h want 01500004 01d00044", wr_log[6'(wb)], wr_log[6'(wb + 1)]);
        else n_pass++;
        n_checks++;
        if (done_drop[6'(db)] !== 1'b0) $display("FAIL clu_bcast_drop got %b want 0", done_drop[6'(db)]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_match(0, "match");
        test_drop();
        test_wrap();
        test_match(3, "gapped");
        test_back_to_back();
        test_reset_mid_packet();
        test_cluster();
        n_checks++;
        if (stray_drop != 0) $display("FAIL stray_drop got %0d want 0", stray_drop);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
